// File: rtl/bin2bcd_signed_seq_pkg.sv
// Shared types and constants for the signed binary-to-BCD converter.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  localparam bcd_digit_t  BCD_ADJ_THRESH = 4'd5;
  localparam bcd_digit_t  BCD_ADJ_ADD    = 4'd3;
  localparam int unsigned SAT_MAX        = 32'd99;

endpackage

// File: rtl/bin2bcd_signed_seq_if.sv
// Request/result bundle between a requester (master) and the converter (slave).
interface bin2bcd_signed_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] bin;
  logic             busy;
  logic             done;
  logic [3:0]       units;
  logic [3:0]       tens;
  logic [3:0]       hundreds;
  logic             neg;
  logic             ovf;

  modport master (
    output start, bin,
    input  busy, done, units, tens, hundreds, neg, ovf
  );

  modport slave (
    input  start, bin,
    output busy, done, units, tens, hundreds, neg, ovf
  );
endinterface

// File: rtl/bin2bcd_signed_seq_add3.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_add3
  import bcd_pkg::*;
(
  input  bcd_digit_t d_i,
  output bcd_digit_t d_o
);

  always_comb begin
    if (d_i >= BCD_ADJ_THRESH) begin
      d_o = d_i + BCD_ADJ_ADD;
    end else begin
      d_o = d_i;
    end
  end

endmodule

// File: rtl/bin2bcd_signed_seq.sv
// Sequential signed binary-to-BCD converter (shift-add-3, one bit per cycle).
// Optional magnitude clamp to 99 with overflow flag: define BIN2BCD_SAT99_EN.
module bin2bcd_signed_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ND    = 3
)(
  input  logic                 clk,
  input  logic                 rst_n,
  bin2bcd_signed_seq_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    mag_q, mag_d;
  logic [4*ND-1:0]     bcd_q, bcd_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                sign_q, sign_d;
  logic                nz_q, nz_d;
  logic                clamp_q, clamp_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  bcd_digit_t          units_q, units_d;
  bcd_digit_t          tens_q, tens_d;
  bcd_digit_t          hundreds_q, hundreds_d;
  logic                neg_q, neg_d;
  logic                ovf_q, ovf_d;

  logic [4*ND-1:0]       adj_s;
  logic [4*ND+WIDTH-1:0] shift_s;
  logic [WIDTH-1:0]      abs_s;

  for (genvar g = 0; g < ND; g++) begin : g_adj
    bcd_add3 u_add3 (
      .d_i (bcd_q[4*g +: 4]),
      .d_o (adj_s[4*g +: 4])
    );
  end

  assign shift_s = {adj_s[4*ND-2:0], mag_q, 1'b0};

  // Most negative input wraps to its own bit pattern, which read unsigned is the true magnitude.
  assign abs_s = bus.bin[WIDTH-1] ? ((~bus.bin) + {{(WIDTH-1){1'b0}}, 1'b1}) : bus.bin;

  always_comb begin
    state_d    = state_q;
    mag_d      = mag_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    sign_d     = sign_q;
    nz_d       = nz_q;
    clamp_d    = clamp_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    units_d    = units_q;
    tens_d     = tens_q;
    hundreds_d = hundreds_q;
    neg_d      = neg_q;
    ovf_d      = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
`ifdef BIN2BCD_SAT99_EN
          if (32'(abs_s) > SAT_MAX) begin
            mag_d   = WIDTH'(SAT_MAX);
            clamp_d = 1'b1;
          end else begin
            mag_d   = abs_s;
            clamp_d = 1'b0;
          end
`else
          mag_d   = abs_s;
          clamp_d = 1'b0;
`endif
          sign_d  = bus.bin[WIDTH-1];
          nz_d    = |abs_s;
          bcd_d   = '0;
          cnt_d   = CNT_INIT;
          busy_d  = 1'b1;
          state_d = CONV;
        end else begin
          state_d = IDLE;
        end
      end
      CONV: begin
        bcd_d = shift_s[WIDTH +: 4*ND];
        mag_d = shift_s[WIDTH-1:0];
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          units_d = shift_s[WIDTH +: 4];
          tens_d  = shift_s[WIDTH+4 +: 4];
`ifdef BIN2BCD_SAT99_EN
          hundreds_d = 4'd0;
`else
          hundreds_d = shift_s[WIDTH+8 +: 4];
`endif
          neg_d   = sign_q & nz_q;
          ovf_d   = clamp_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = CONV;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Converter state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mag_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      sign_q     <= 1'b0;
      nz_q       <= 1'b0;
      clamp_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      units_q    <= 4'd0;
      tens_q     <= 4'd0;
      hundreds_q <= 4'd0;
      neg_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mag_q      <= mag_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      sign_q     <= sign_d;
      nz_q       <= nz_d;
      clamp_q    <= clamp_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      units_q    <= units_d;
      tens_q     <= tens_d;
      hundreds_q <= hundreds_d;
      neg_q      <= neg_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.units    = units_q;
  assign bus.tens     = tens_q;
  assign bus.hundreds = hundreds_q;
  assign bus.neg      = neg_q;
`ifdef BIN2BCD_SAT99_EN
  assign bus.ovf      = ovf_q;
`else
  assign bus.ovf      = 1'b0;
`endif

endmodule

// File: tb/tb_bin2bcd_signed_seq.sv
// Directed scoreboard bench for bin2bcd_signed_seq (honours BIN2BCD_SAT99_EN).
module tb_bin2bcd_signed_seq;

  typedef struct {
    logic [3:0] u;
    logic [3:0] t;
    logic [3:0] h;
    logic       n;
    logic       o;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  exp_t last;

  bin2bcd_signed_seq_if #(.WIDTH(8)) bus ();

  bin2bcd_signed_seq #(.WIDTH(8), .ND(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int v);
    exp_t e;
    int   m;
    m   = (v < 0) ? -v : v;
    e.o = 1'b0;
`ifdef BIN2BCD_SAT99_EN
    if (m > 99) begin
      m   = 99;
      e.o = 1'b1;
    end
`endif
    e.h = 4'(m / 100);
    e.t = 4'((m / 10) % 10);
    e.u = 4'(m % 10);
    e.n = (v < 0);
    return e;
  endfunction

  task automatic launch(input int v);
    bus.bin   = 8'(v);
    bus.start = 1'b1;
    sb.push_back(model(v));
  endtask

  // Waits for done; optionally fires an extra (should-be-ignored) start at cycle inj.
  task automatic finish_conv(input string tag, input int inj, input int inj_val);
    int   lat;
    exp_t e;
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.start = 1'b0;
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
      end
      if (k == inj) begin
        bus.bin   = 8'(inj_val);
        bus.start = 1'b1;
      end
      if (k == inj + 1) begin
        bus.start = 1'b0;
      end
      if (k == 4) begin
        check({tag, "_hold_u"}, 32'(bus.units), 32'(last.u));
        check({tag, "_hold_t"}, 32'(bus.tens), 32'(last.t));
      end
      if (bus.done === 1'b1) begin
        lat = k - 1;
        break;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'd8);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_units"}, 32'(bus.units), 32'(e.u));
      check({tag, "_tens"}, 32'(bus.tens), 32'(e.t));
      check({tag, "_hundreds"}, 32'(bus.hundreds), 32'(e.h));
      check({tag, "_neg"}, 32'(bus.neg), 32'(e.n));
      check({tag, "_ovf"}, 32'(bus.ovf), 32'(e.o));
      check({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
      last = e;
    end
  endtask

  task automatic count_dones(input string tag, input int n, input int exp);
    int cnt;
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) cnt++;
    end
    check(tag, 32'(cnt), 32'(exp));
  endtask

  initial begin
    bus.start = 1'b0;
    bus.bin   = 8'd0;
    last      = model(0);
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_digits", {20'd0, bus.hundreds, bus.tens, bus.units}, 32'd0);
    check("rst_flags", {30'd0, bus.neg, bus.ovf}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    launch(37);            finish_conv("p37", 0, 0);
    @(negedge clk);
    check("p37_done_pulse", 32'(bus.done), 32'd0);
    launch(-45);           finish_conv("m45", 0, 0);
    @(negedge clk);
    launch(-128);          finish_conv("m128", 0, 0);
    @(negedge clk);
    launch(0);             finish_conv("zero", 0, 0);
    @(negedge clk);
    launch(127);           finish_conv("p127", 0, 0);
    @(negedge clk);

    // Start while busy must be dropped, not queued.
    launch(12);            finish_conv("busy12", 3, 99);
    count_dones("busy_no_extra_done", 14, 0);

    // Back-to-back: new start presented during the done cycle.
    launch(-7);            finish_conv("b2b_first", 0, 0);
    launch(55);            finish_conv("b2b_55", 0, 0);
    @(negedge clk);

    // Reset mid-conversion aborts without a done.
    launch(64);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
    end
    rst_n = 1'b0;
    void'(sb.pop_front());
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_digits", {20'd0, bus.hundreds, bus.tens, bus.units}, 32'd0);
    check("abort_neg", 32'(bus.neg), 32'd0);
    count_dones("abort_in_reset", 3, 0);
    rst_n = 1'b1;
    count_dones("abort_no_done", 12, 0);
    last = model(0);
    launch(9);             finish_conv("after_rst9", 0, 0);
    @(negedge clk);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
